// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - register-file geometry shared by the rf, decode and writeback logic
package rf_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam logic [RF_AW-1:0] REG_ZERO = 5'd0;

  // Wide enough to name any of up to 8 writeback requesters
  localparam int GNT_W = 3;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter; owns the rotating priority pointer
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [GNT_W-1:0] gnt_idx
);

  logic [GNT_W-1:0] ptr_q;
  logic [GNT_W-1:0] ptr_d;
  logic             found;
  int               slot;

  // Walk the slots starting at the pointer; the first requesting slot wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    slot    = 0;
    for (int k = 0; k < N; k++) begin
      slot = int'(ptr_q) + k;
      if (slot >= N) slot = slot - N;
      for (int i = 0; i < N; i++) begin
        if (!found && (i == slot) && req[i]) begin
          found   = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = GNT_W'(i);
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (gnt_idx == GNT_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - shares the rf write port among NREQ writeback requesters
// Define RF_WB_PIPE_EN to register write/write_reg/write_data (latency 1).
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_reg,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               write,
  output logic [AW-1:0]      write_reg,
  output logic [DW-1:0]      write_data,
  output logic [2:0]         grant_id,
  output logic [15:0]        drop_cnt
);

  logic [NREQ-1:0]  gnt;
  logic [GNT_W-1:0] gnt_idx;
  logic             accept;
  logic [AW-1:0]    win_reg;
  logic [DW-1:0]    win_data;
  logic             is_zero;
  logic             wr_c;
  logic [AW-1:0]    wr_reg_c;
  logic [DW-1:0]    wr_data_c;

  logic [2:0]       grant_id_q, grant_id_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  // Nothing is accepted while reset is held, so requesters see ready=0
  assign accept = rst & (|req_valid);

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = accept ? gnt : '0;

  always_comb begin
    win_reg  = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_reg  = req_reg[i*AW +: AW];
        win_data = req_data[i*DW +: DW];
      end
    end
  end

  // Register-0 writes complete the handshake but never reach the rf
  assign is_zero   = (win_reg == AW'(REG_ZERO));
  assign wr_c      = accept & ~is_zero;
  assign wr_reg_c  = wr_c ? win_reg : '0;
  assign wr_data_c = wr_c ? win_data : '0;

  always_comb begin
    grant_id_d = grant_id_q;
    drop_cnt_d = drop_cnt_q;
    if (accept) grant_id_d = 3'(gnt_idx);
    if (accept && is_zero && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_id_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      grant_id_q <= grant_id_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign grant_id = grant_id_q;
  assign drop_cnt = drop_cnt_q;

`ifdef RF_WB_PIPE_EN
  logic          write_q, write_d;
  logic [AW-1:0] write_reg_q, write_reg_d;
  logic [DW-1:0] write_data_q, write_data_d;

  always_comb begin
    write_d      = wr_c;
    write_reg_d  = wr_reg_c;
    write_data_d = wr_data_c;
  end

  // Async clear discards a pending write the moment reset falls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q      <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      write_q      <= write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign write      = write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
`else
  assign write      = wr_c;
  assign write_reg  = wr_reg_c;
  assign write_data = wr_data_c;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic        write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [2:0]  grant_id;
  logic [15:0] drop_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rf_wb_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_reg    (req_reg),
    .req_data   (req_data),
    .write      (write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .grant_id   (grant_id),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
    req_reg[i*5 +: 5]   = r;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'h1); set_req(1, 5'd2, 32'h2); set_req(2, 5'd3, 32'h3);
    #2;
    total_cnt++; if (req_ready !== 3'b000) $display("FAIL reset_ready got %b want 000", req_ready); else pass_cnt++;
    total_cnt++; if (write !== 1'b0) $display("FAIL reset_write got %b want 0", write); else pass_cnt++;
    tick();
    total_cnt++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop got %0d want 0", drop_cnt); else pass_cnt++;
    total_cnt++; if (grant_id !== 3'd0) $display("FAIL reset_grant got %0d want 0", grant_id); else pass_cnt++;
    total_cnt++; if (write !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0)
      $display("FAIL reset_wrport got %b/%0d/%h want 0/0/0", write, write_reg, write_data); else pass_cnt++;
    req_valid = 3'b000;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req_valid = 3'b010;
    set_req(1, 5'd7, 32'hDEAD_BEEF);
    #2;
    total_cnt++; if (req_ready !== 3'b010) $display("FAIL single_ready got %b want 010", req_ready); else pass_cnt++;
`ifndef RF_WB_PIPE_EN
    total_cnt++; if (write !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'hDEAD_BEEF)
      $display("FAIL single_write got %b/%0d/%h want 1/7/deadbeef", write, write_reg, write_data); else pass_cnt++;
`endif
    tick();
    req_valid = 3'b000;
`ifdef RF_WB_PIPE_EN
    total_cnt++; if (write !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'hDEAD_BEEF)
      $display("FAIL single_write got %b/%0d/%h want 1/7/deadbeef", write, write_reg, write_data); else pass_cnt++;
`endif
    total_cnt++; if (grant_id !== 3'd1) $display("FAIL single_grant got %0d want 1", grant_id); else pass_cnt++;
    tick();
    total_cnt++; if (write !== 1'b0) $display("FAIL single_idle_write got %b want 0", write); else pass_cnt++;
  endtask

  task automatic test_wrap();
    req_valid = 3'b001;
    set_req(0, 5'd4, 32'h4444_0000);
    #2;
    total_cnt++; if (req_ready !== 3'b001) $display("FAIL wrap_ready got %b want 001", req_ready); else pass_cnt++;
    tick();
    total_cnt++; if (grant_id !== 3'd0) $display("FAIL wrap_grant got %0d want 0", grant_id); else pass_cnt++;
    req_valid = 3'b111;
    set_req(1, 5'd5, 32'h5); set_req(2, 5'd6, 32'h6);
    #2;
    total_cnt++; if (req_ready !== 3'b010) $display("FAIL wrap_ptr got %b want 010", req_ready); else pass_cnt++;
    tick();
    req_valid = 3'b000;
    total_cnt++; if (grant_id !== 3'd1) $display("FAIL wrap_grant2 got %0d want 1", grant_id); else pass_cnt++;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    int wcount = 0;
    logic [2:0] exp_rdy;
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'hA000_0000); set_req(1, 5'd2, 32'hA000_0001); set_req(2, 5'd3, 32'hA000_0002);
    for (int k = 0; k < 6; k++) begin
      exp_rdy = 3'b001 << (k % 3);
      #2;
      total_cnt++; if (req_ready !== exp_rdy) $display("FAIL fair_ready[%0d] got %b want %b", k, req_ready, exp_rdy); else pass_cnt++;
`ifndef RF_WB_PIPE_EN
      if (write === 1'b1) wcount++;
      total_cnt++; if (write_reg !== 5'(k % 3 + 1)) $display("FAIL fair_reg[%0d] got %0d want %0d", k, write_reg, k % 3 + 1); else pass_cnt++;
`endif
      tick();
`ifdef RF_WB_PIPE_EN
      if (write === 1'b1) wcount++;
      total_cnt++; if (write_reg !== 5'(k % 3 + 1)) $display("FAIL fair_reg[%0d] got %0d want %0d", k, write_reg, k % 3 + 1); else pass_cnt++;
`endif
      total_cnt++; if (grant_id !== 3'(k % 3)) $display("FAIL fair_grant[%0d] got %0d want %0d", k, grant_id, k % 3); else pass_cnt++;
    end
    req_valid = 3'b000;
    total_cnt++; if (wcount != 6) $display("FAIL fair_writes got %0d want 6", wcount); else pass_cnt++;
    tick();
    total_cnt++; if (write !== 1'b0) $display("FAIL fair_idle_write got %b want 0", write); else pass_cnt++;
  endtask

  task automatic test_zero_drop();
    req_valid = 3'b001;
    set_req(0, 5'd0, 32'hBAD0_0000);
    for (int k = 0; k < 3; k++) begin
      #2;
      total_cnt++; if (req_ready !== 3'b001) $display("FAIL zero_ready[%0d] got %b want 001", k, req_ready); else pass_cnt++;
`ifndef RF_WB_PIPE_EN
      total_cnt++; if (write !== 1'b0) $display("FAIL zero_write[%0d] got %b want 0", k, write); else pass_cnt++;
`endif
      tick();
`ifdef RF_WB_PIPE_EN
      total_cnt++; if (write !== 1'b0) $display("FAIL zero_write[%0d] got %b want 0", k, write); else pass_cnt++;
`endif
    end
    req_valid = 3'b000;
    total_cnt++; if (drop_cnt !== 16'd3) $display("FAIL zero_drop got %0d want 3", drop_cnt); else pass_cnt++;
    total_cnt++; if (grant_id !== 3'd0) $display("FAIL zero_grant got %0d want 0", grant_id); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 3'b010;
    set_req(1, 5'd9, 32'h1234_5678);
    tick();
    total_cnt++; if (grant_id !== 3'd1) $display("FAIL mid_grant got %0d want 1", grant_id); else pass_cnt++;
    total_cnt++; if (write !== 1'b1 || write_reg !== 5'd9) $display("FAIL mid_pending got %b/%0d want 1/9", write, write_reg); else pass_cnt++;
    #2;
    rst = 1'b0;
    #1;
    total_cnt++; if (write !== 1'b0 || write_reg !== 5'd0) $display("FAIL mid_write got %b/%0d want 0/0", write, write_reg); else pass_cnt++;
    total_cnt++; if (req_ready !== 3'b000) $display("FAIL mid_ready got %b want 000", req_ready); else pass_cnt++;
    tick();
    total_cnt++; if (write !== 1'b0) $display("FAIL mid_noedge_write got %b want 0", write); else pass_cnt++;
    total_cnt++; if (grant_id !== 3'd0 || drop_cnt !== 16'd0) $display("FAIL mid_state got %0d/%0d want 0/0", grant_id, drop_cnt); else pass_cnt++;
    rst = 1'b1;
    req_valid = 3'b100;
    set_req(2, 5'd11, 32'hCAFE_F00D);
    #2;
    total_cnt++; if (req_ready !== 3'b100) $display("FAIL mid_resume got %b want 100", req_ready); else pass_cnt++;
    tick();
    req_valid = 3'b000;
    total_cnt++; if (grant_id !== 3'd2) $display("FAIL mid_resume_grant got %0d want 2", grant_id); else pass_cnt++;
    tick();
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 3'b000;
    req_reg   = '0;
    req_data  = '0;
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_zero_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
